mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (DwAddress/DwWriteData/DwReadData/strobes) of the multicycle
//  RISC-V core between two requesters: port 0 = CPU datapath, port 1 = auxiliary master (DMA/loader).
//  Sequences each access through a fixed-latency memory with a req/ack handshake.
//  Fixed priority to port 0, with a starvation limit that forces a port 1 grant.
// PARAMETERS
//  MEM_LATENCY   1  cycles the memory needs from address valid to read data valid; must be >=1
//  STARVE_LIMIT  4  consecutive port-0 grants while port 1 is pending, after which port 1 wins
// PORTS
//  iCLK        in   1   system clock; all state updates on rising edge
//  iRST        in   1   synchronous, active-high reset
//  iReq0       in   1   port 0 request; held with fields stable until oAck0
//  iWe0        in   1   port 0 write (1) / read (0)
//  iAddr0      in   32  port 0 byte address
//  iWData0     in   32  port 0 write data
//  iBE0        in   4   port 0 byte enables
//  oAck0       out  1   one-cycle completion pulse for port 0
//  oRData0     out  32  port 0 read data; valid with oAck0, held until next oAck0
//  iReq1, iWe1, iAddr1, iWData1, iBE1, oAck1, oRData1: identical set for port 1
//  oMemAddr    out  32  memory address
//  oMemWData   out  32  memory write data
//  oMemBE      out  4   memory byte enables
//  oMemWE      out  1   memory write strobe
//  oMemRE      out  1   memory read strobe
//  iMemRData   in   32  memory read data
//  oGrant      out  2   one-hot current owner (bit0 = port 0, bit1 = port 1); 0 when idle
//  oBusy       out  1   1 whenever the state is not IDLE
// BEHAVIOUR
//  - Reset: state IDLE, latency counter 0, starve counter 0, all outputs 0 (incl. oRData0/1).
//    Reset mid-access aborts it: no ack issued, strobes 0 from the cycle after the reset edge.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. No back-to-back bypass; each access costs MEM_LATENCY+2 cycles.
//  - IDLE (cycle 0): if iReq0|iReq1, pick winner, latch its addr/wdata/be/we/owner, load lat_cnt =
//    MEM_LATENCY-1, go ACCESS. Winner: port 1 if (iReq1 & ~iReq0) or (iReq1 & starve_cnt == STARVE_LIMIT);
//    otherwise port 0.
//  - Starve counter: +1 (saturating at STARVE_LIMIT) when port 0 is granted while iReq1=1; cleared when
//    port 1 is granted; unchanged otherwise.
//  - ACCESS (cycles 1..MEM_LATENCY): oMemAddr/oMemWData/oMemBE driven from latched values.
//    Read: oMemRE=1 for every ACCESS cycle. Write: oMemWE=1 in the first ACCESS cycle only; oMemRE=0.
//    lat_cnt decrements each cycle; at lat_cnt==0 capture iMemRData (reads) and go RESP.
//  - RESP (cycle MEM_LATENCY+1): oAckN=1 for the owner only; oRDataN updated on reads (unchanged on
//    writes); go IDLE. Requests are not sampled in ACCESS/RESP.
//  - Outside ACCESS, oMemAddr/oMemWData/oMemBE/oMemWE/oMemRE = 0. oGrant valid in ACCESS and RESP.
//  - Requester may deassert or re-raise iReq the cycle after its ack; a still-high iReq after ack is
//    treated as a new request in the following IDLE cycle.
//  - Simultaneous requests with STARVE_LIMIT reached: port 1 wins, port 0 served next arbitration.
//  - Address/data are passed through unmodified (no alignment or width change).
// TESTING
//  1. MEM_LATENCY=1, port 0 read 0x00400000, mem returns 0x00000013 -> oMemRE=1 in cycle 1 only,
//     oAck0 in cycle 2, oRData0=0x00000013, oAck1 never asserted.
//  2. Port 0 write 0x10010004 <- 0xDEADBEEF, BE=4'hF -> oMemWE=1 exactly in cycle 1, oMemRE=0, oAck0 in
//     cycle 2, oRData0 unchanged.
//  3. iReq0=iReq1=1 held, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1 (one per 3 cycles).
//  4. Port 1 alone reads 0x10010000; iReq0 raised during its ACCESS -> oAck1 first, then port 0 granted
//     in the next IDLE cycle, oAck0 3 cycles later.
//  5. MEM_LATENCY=3, port 0 read -> oMemRE=1 in cycles 1-3, data sampled in cycle 3, oAck0 in cycle 4.
//  6. iRST pulsed in cycle 1 of a read -> no ack, all outputs 0 next cycle, starve counter 0;
//     a new port 1 request then completes normally in MEM_LATENCY+2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets two requesters share one fixed-latency data-memory port through a req/ack
//   handshake. Port 0 (CPU datapath) has fixed priority over port 1 (auxiliary master).
//   Port 1 is forced through after STARVE_LIMIT consecutive port-0 grants while it waits.
//   Each access walks IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP. There is no bypass,
//   so every access costs MEM_LATENCY+2 cycles.
//
// Parameters
//   MEM_LATENCY   cycles from address valid to read data valid (>= 1)
//   STARVE_LIMIT  port-0 grants while port 1 is pending before port 1 wins
//
// Ports
//   iCLK, iRST                clock, synchronous active-high reset
//   iReqN/iWeN/iAddrN/        port N request; fields are held stable until oAckN
//   iWDataN/iBEN
//   oAckN                     one-cycle completion pulse for port N
//   oRDataN                   port N read data; valid with oAckN, held until the next oAckN
//   oMemAddr/oMemWData/       memory-side address, data, byte enables and strobes;
//   oMemBE/oMemWE/oMemRE      all zero outside ACCESS
//   iMemRData                 memory read data
//   oGrant                    one-hot owner in ACCESS/RESP; zero when idle
//   oBusy                     high whenever the FSM is not idle
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq0,
  input  logic        iWe0,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iWData0,
  input  logic [3:0]  iBE0,
  output logic        oAck0,
  output logic [31:0] oRData0,
  input  logic        iReq1,
  input  logic        iWe1,
  input  logic [31:0] iAddr1,
  input  logic [31:0] iWData1,
  input  logic [3:0]  iBE1,
  output logic        oAck1,
  output logic [31:0] oRData1,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBE,
  output logic        oMemWE,
  output logic        oMemRE,
  input  logic [31:0] iMemRData,
  output logic [1:0]  oGrant,
  output logic        oBusy
);

  localparam int unsigned LatW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LatW-1:0]    LatInit   = LatW'(MEM_LATENCY - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              r_state;
  logic [LatW-1:0]     r_lat_cnt;
  logic [StarveW-1:0]  r_starve_cnt;
  logic                r_we;

  logic w_any_req;
  logic w_pick1;

  assign w_any_req = iReq0 | iReq1;
  // Port 1 wins when it is alone, or when port 0 has starved it long enough.
  assign w_pick1   = iReq1 & (~iReq0 | (r_starve_cnt == StarveMax));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= StIdle;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_we         <= 1'b0;
      oAck0        <= 1'b0;
      oAck1        <= 1'b0;
      oRData0      <= '0;
      oRData1      <= '0;
      oMemAddr     <= '0;
      oMemWData    <= '0;
      oMemBE       <= '0;
      oMemWE       <= 1'b0;
      oMemRE       <= 1'b0;
      oGrant       <= '0;
      oBusy        <= 1'b0;
    end else begin
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state   <= StAccess;
            r_lat_cnt <= LatInit;
            oBusy     <= 1'b1;
            // The memory-side output registers double as the latched request fields.
            if (w_pick1) begin
              oGrant       <= 2'b10;
              r_we         <= iWe1;
              oMemAddr     <= iAddr1;
              oMemWData    <= iWData1;
              oMemBE       <= iBE1;
              oMemWE       <= iWe1;
              oMemRE       <= ~iWe1;
              r_starve_cnt <= '0;
            end else begin
              oGrant    <= 2'b01;
              r_we      <= iWe0;
              oMemAddr  <= iAddr0;
              oMemWData <= iWData0;
              oMemBE    <= iBE0;
              oMemWE    <= iWe0;
              oMemRE    <= ~iWe0;
              if (iReq1 && (r_starve_cnt != StarveMax)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end
          end
        end
        StAccess: begin
          // Write strobe lasts for the first access cycle only.
          oMemWE <= 1'b0;
          if (r_lat_cnt == '0) begin
            r_state   <= StResp;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemBE    <= '0;
            oMemRE    <= 1'b0;
            oAck0     <= oGrant[0];
            oAck1     <= oGrant[1];
            if (!r_we) begin
              if (oGrant[1]) begin
                oRData1 <= iMemRData;
              end else begin
                oRData0 <= iMemRData;
              end
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        StResp: begin
          r_state <= StIdle;
          oGrant  <= '0;
          oBusy   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances share all inputs: d1 uses
//   MEM_LATENCY=1, d3 uses MEM_LATENCY=3. Inputs change 1 time unit after a rising edge
//   and outputs are sampled at that same point.
module tb_mem_port_arbiter;

  logic        iCLK;
  logic        iRST;
  logic        iReq0, iWe0, iReq1, iWe1;
  logic [31:0] iAddr0, iWData0, iAddr1, iWData1, iMemRData;
  logic [3:0]  iBE0, iBE1;

  logic        d1_ack0, d1_ack1, d1_we, d1_re, d1_busy;
  logic [31:0] d1_rdata0, d1_rdata1, d1_addr, d1_wdata;
  logic [3:0]  d1_be;
  logic [1:0]  d1_grant;

  logic        d3_ack0, d3_ack1, d3_we, d3_re, d3_busy;
  logic [31:0] d3_rdata0, d3_rdata1, d3_addr, d3_wdata;
  logic [3:0]  d3_be;
  logic [1:0]  d3_grant;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) d1 (
    .iCLK(iCLK), .iRST(iRST),
    .iReq0(iReq0), .iWe0(iWe0), .iAddr0(iAddr0), .iWData0(iWData0), .iBE0(iBE0),
    .oAck0(d1_ack0), .oRData0(d1_rdata0),
    .iReq1(iReq1), .iWe1(iWe1), .iAddr1(iAddr1), .iWData1(iWData1), .iBE1(iBE1),
    .oAck1(d1_ack1), .oRData1(d1_rdata1),
    .oMemAddr(d1_addr), .oMemWData(d1_wdata), .oMemBE(d1_be), .oMemWE(d1_we),
    .oMemRE(d1_re), .iMemRData(iMemRData), .oGrant(d1_grant), .oBusy(d1_busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) d3 (
    .iCLK(iCLK), .iRST(iRST),
    .iReq0(iReq0), .iWe0(iWe0), .iAddr0(iAddr0), .iWData0(iWData0), .iBE0(iBE0),
    .oAck0(d3_ack0), .oRData0(d3_rdata0),
    .iReq1(iReq1), .iWe1(iWe1), .iAddr1(iAddr1), .iWData1(iWData1), .iBE1(iBE1),
    .oAck1(d3_ack1), .oRData1(d3_rdata1),
    .oMemAddr(d3_addr), .oMemWData(d3_wdata), .oMemBE(d3_be), .oMemWE(d3_we),
    .oMemRE(d3_re), .iMemRData(iMemRData), .oGrant(d3_grant), .oBusy(d3_busy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({d1_ack0, d1_ack1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ack: got %b want 00", {d1_ack0, d1_ack1});
    end
    n_checks++;
    if ({d1_rdata0, d1_rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {d1_rdata0, d1_rdata1});
    end
    n_checks++;
    if ({d1_addr, d1_wdata, d1_be, d1_we, d1_re} !== 70'h0) begin
      n_fail++; $display("FAIL reset_mem: got %h want 0", {d1_addr, d1_wdata, d1_be, d1_we, d1_re});
    end
    n_checks++;
    if ({d1_grant, d1_busy, d3_grant, d3_busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_grant_busy: got %b want 0", {d1_grant, d1_busy, d3_grant, d3_busy});
    end
    iRST = 1'b0;
    tick();
  endtask

  task automatic test_read();
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h0040_0000; iBE0 = 4'hF;
    iMemRData = 32'h0000_0013;
    tick();  // cycle 1
    n_checks++;
    if ({d1_re, d1_we} !== 2'b10) begin
      n_fail++; $display("FAIL read_strobes_c1: got re/we %b want 10", {d1_re, d1_we});
    end
    n_checks++;
    if (d1_addr !== 32'h0040_0000) begin
      n_fail++; $display("FAIL read_addr_c1: got %h want 00400000", d1_addr);
    end
    n_checks++;
    if ({d1_grant, d1_busy, d1_ack0} !== 4'b0110) begin
      n_fail++; $display("FAIL read_grant_c1: got %b want 0110", {d1_grant, d1_busy, d1_ack0});
    end
    tick();  // cycle 2
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_re} !== 3'b100) begin
      n_fail++; $display("FAIL read_ack_c2: got ack0/ack1/re %b want 100", {d1_ack0, d1_ack1, d1_re});
    end
    n_checks++;
    if (d1_rdata0 !== 32'h0000_0013) begin
      n_fail++; $display("FAIL read_rdata0: got %h want 00000013", d1_rdata0);
    end
    iReq0 = 1'b0;
    tick();  // back to idle
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_busy, d1_grant} !== 5'b0) begin
      n_fail++; $display("FAIL read_idle_c3: got %b want 00000", {d1_ack0, d1_ack1, d1_busy, d1_grant});
    end
  endtask

  task automatic test_write();
    iReq0 = 1'b1; iWe0 = 1'b1; iAddr0 = 32'h1001_0004; iWData0 = 32'hDEAD_BEEF; iBE0 = 4'hF;
    iMemRData = 32'hBAAD_F00D;
    tick();  // cycle 1
    n_checks++;
    if ({d1_we, d1_re} !== 2'b10) begin
      n_fail++; $display("FAIL write_strobes_c1: got we/re %b want 10", {d1_we, d1_re});
    end
    n_checks++;
    if ({d1_addr, d1_wdata, d1_be} !== {32'h1001_0004, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++; $display("FAIL write_fields_c1: got %h %h %h", d1_addr, d1_wdata, d1_be);
    end
    tick();  // cycle 2
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_we, d1_re} !== 4'b1000) begin
      n_fail++; $display("FAIL write_ack_c2: got %b want 1000", {d1_ack0, d1_ack1, d1_we, d1_re});
    end
    n_checks++;
    if (d1_rdata0 !== 32'h0000_0013) begin
      n_fail++; $display("FAIL write_rdata0_kept: got %h want 00000013", d1_rdata0);
    end
    iReq0 = 1'b0; iWe0 = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    int exp_port [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [1:0] exp_g;
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h0040_0004;
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 32'h2000_0000;
    iMemRData = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      exp_g = (exp_port[i] == 1) ? 2'b10 : 2'b01;
      tick();
      n_checks++;
      if (d1_grant !== exp_g) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got %b want %b", i, d1_grant, exp_g);
      end
      tick();
      n_checks++;
      if ({d1_ack1, d1_ack0} !== exp_g) begin
        n_fail++; $display("FAIL starve_ack[%0d]: got %b want %b", i, {d1_ack1, d1_ack0}, exp_g);
      end
      if (i == 9) begin
        iReq0 = 1'b0; iReq1 = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_port1_then_port0();
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 32'h1001_0000; iMemRData = 32'hCAFE_0001;
    tick();  // cycle 1
    n_checks++;
    if ({d1_grant, d1_re} !== 3'b101) begin
      n_fail++; $display("FAIL p1_grant_c1: got %b want 101", {d1_grant, d1_re});
    end
    n_checks++;
    if (d1_addr !== 32'h1001_0000) begin
      n_fail++; $display("FAIL p1_addr_c1: got %h want 10010000", d1_addr);
    end
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h0040_0010;
    tick();  // cycle 2
    n_checks++;
    if ({d1_ack1, d1_ack0} !== 2'b10) begin
      n_fail++; $display("FAIL p1_ack_c2: got %b want 10", {d1_ack1, d1_ack0});
    end
    n_checks++;
    if (d1_rdata1 !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL p1_rdata1: got %h want cafe0001", d1_rdata1);
    end
    iReq1 = 1'b0; iMemRData = 32'h0000_ABCD;
    tick();  // cycle 3 idle
    n_checks++;
    if ({d1_busy, d1_grant} !== 3'b000) begin
      n_fail++; $display("FAIL p1_idle_c3: got %b want 000", {d1_busy, d1_grant});
    end
    tick();  // cycle 4
    n_checks++;
    if ({d1_grant, d1_addr} !== {2'b01, 32'h0040_0010}) begin
      n_fail++; $display("FAIL p0_grant_c4: got %b %h", d1_grant, d1_addr);
    end
    tick();  // cycle 5
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_rdata0} !== {2'b10, 32'h0000_ABCD}) begin
      n_fail++; $display("FAIL p0_ack_c5: got %b %h", {d1_ack0, d1_ack1}, d1_rdata0);
    end
    n_checks++;
    if (d1_rdata1 !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL p0_rdata1_kept: got %h want cafe0001", d1_rdata1);
    end
    iReq0 = 1'b0;
    tick();
  endtask

  task automatic test_latency3();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h0040_0020; iMemRData = 32'hFFFF_FFFF;
    tick();  // cycle 1
    n_checks++;
    if ({d3_re, d3_grant, d3_ack0} !== 4'b1010) begin
      n_fail++; $display("FAIL lat3_c1: got %b want 1010", {d3_re, d3_grant, d3_ack0});
    end
    tick();  // cycle 2
    n_checks++;
    if ({d3_re, d3_ack0} !== 2'b10) begin
      n_fail++; $display("FAIL lat3_c2: got %b want 10", {d3_re, d3_ack0});
    end
    tick();  // cycle 3: only now does the memory present the real data
    iMemRData = 32'h00A0_B0C0;
    n_checks++;
    if ({d3_re, d3_ack0, d3_addr} !== {2'b10, 32'h0040_0020}) begin
      n_fail++; $display("FAIL lat3_c3: got %b %h", {d3_re, d3_ack0}, d3_addr);
    end
    tick();  // cycle 4
    iMemRData = 32'h1111_1111;
    n_checks++;
    if ({d3_ack0, d3_ack1, d3_re} !== 3'b100) begin
      n_fail++; $display("FAIL lat3_ack_c4: got %b want 100", {d3_ack0, d3_ack1, d3_re});
    end
    n_checks++;
    if (d3_rdata0 !== 32'h00A0_B0C0) begin
      n_fail++; $display("FAIL lat3_rdata0: got %h want 00a0b0c0", d3_rdata0);
    end
    iReq0 = 1'b0;
    tick();
    n_checks++;
    if ({d3_busy, d3_grant, d3_ack0} !== 4'b0) begin
      n_fail++; $display("FAIL lat3_idle_c5: got %b want 0000", {d3_busy, d3_grant, d3_ack0});
    end
  endtask

  task automatic test_reset_mid_access();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    // Three contested port-0 grants, then a fourth leaves the starve counter at its limit.
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h0040_0030;
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 32'h1001_0008;
    iMemRData = 32'h600D_D00D;
    for (int i = 0; i < 3; i++) begin
      tick(); tick(); tick();
    end
    tick();  // cycle 1 of the fourth read
    n_checks++;
    if ({d1_grant, d1_re} !== 3'b011) begin
      n_fail++; $display("FAIL rst_pre_c1: got %b want 011", {d1_grant, d1_re});
    end
    iRST = 1'b1; iReq0 = 1'b0; iReq1 = 1'b0;
    tick();
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_grant, d1_busy} !== 5'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {d1_ack0, d1_ack1, d1_grant, d1_busy});
    end
    n_checks++;
    if ({d1_addr, d1_wdata, d1_be, d1_we, d1_re} !== 70'h0) begin
      n_fail++; $display("FAIL rst_mem: got %h want 0", {d1_addr, d1_wdata, d1_be, d1_we, d1_re});
    end
    n_checks++;
    if ({d1_rdata0, d1_rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h want 0", {d1_rdata0, d1_rdata1});
    end
    iRST = 1'b0;
    tick();
    n_checks++;
    if ({d1_ack0, d1_ack1, d1_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_no_late_ack: got %b want 000", {d1_ack0, d1_ack1, d1_busy});
    end
    // Starve counter was cleared: a contested request goes to port 0.
    iReq0 = 1'b1; iReq1 = 1'b1;
    tick();
    n_checks++;
    if (d1_grant !== 2'b01) begin
      n_fail++; $display("FAIL rst_starve_cleared: got %b want 01", d1_grant);
    end
    tick();
    n_checks++;
    if ({d1_ack1, d1_ack0} !== 2'b01) begin
      n_fail++; $display("FAIL rst_p0_ack: got %b want 01", {d1_ack1, d1_ack0});
    end
    iReq0 = 1'b0;
    tick();  // idle, port 1 still requesting
    tick();
    n_checks++;
    if ({d1_grant, d1_addr} !== {2'b10, 32'h1001_0008}) begin
      n_fail++; $display("FAIL rst_p1_grant: got %b %h", d1_grant, d1_addr);
    end
    tick();
    n_checks++;
    if ({d1_ack1, d1_ack0, d1_rdata1} !== {2'b10, 32'h600D_D00D}) begin
      n_fail++; $display("FAIL rst_p1_ack: got %b %h", {d1_ack1, d1_ack0}, d1_rdata1);
    end
    iReq1 = 1'b0;
    tick();
    n_checks++;
    if ({d1_busy, d1_grant} !== 3'b000) begin
      n_fail++; $display("FAIL rst_p1_idle: got %b want 000", {d1_busy, d1_grant});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    iRST = 1'b1;
    iReq0 = 1'b0; iWe0 = 1'b0; iAddr0 = '0; iWData0 = '0; iBE0 = '0;
    iReq1 = 1'b0; iWe1 = 1'b0; iAddr1 = '0; iWData1 = '0; iBE1 = 4'hF;
    iMemRData = '0;
    #1;
    test_reset();
    test_read();
    test_write();
    test_starve();
    test_port1_then_port0();
    test_latency3();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
